// File: rtl/maria_pkg.sv
// Shared definitions for the MARIA DMA master.
//   dma_state_e          : FSM state encoding (idle, halt request, fetch, bus release)
//   HALT_TIMEOUT_DEFAULT : default number of pclk1 pulses to wait for the CPU to halt
//   len_to_count()       : maps the 8-bit length field onto a 9-bit byte count
package maria_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHalt    = 2'd1,
    StFetch   = 2'd2,
    StRelease = 2'd3
  } dma_state_e;

  localparam logic [7:0] HALT_TIMEOUT_DEFAULT = 8'd255;

  // A length of zero encodes a full 256-byte transfer.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/maria_dma_master.sv
// MARIA DMA master: halts the CPU, fetches a block of bytes over the shared
// address/data bus and releases the bus again.
//
// Ports
//   clk_sys    : system clock
//   rst        : synchronous active-high reset, overrides every other input
//   pclk0      : phase-0 enable, one fetch per pulse while in FETCH
//   pclk1      : phase-1 enable, paces the halt timeout
//   start      : one-clk transfer request, honoured only when idle
//   base_addr  : first fetch address (latched on start)
//   len        : byte count, 0 means 256 (latched on start)
//   is_halted  : CPU has released the bus
//   halt_n     : active-low halt request to the CPU
//   AB_out     : fetch address, 16'h0000 when not fetching
//   drive_AB   : AB_out is valid and should be driven onto the bus
//   d_in       : read data bus
//   data_out   : last fetched byte
//   data_valid : one-clk strobe for data_out
//   busy       : a transfer is in progress
//   done       : one-clk end-of-transfer pulse (also after an error)
//   err        : one-clk pulse on halt timeout or CPU reclaiming the bus mid-fetch
module maria_dma_master
  import maria_pkg::*;
#(
  parameter logic [7:0] HALT_TIMEOUT = HALT_TIMEOUT_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pclk0,
  input  logic        pclk1,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [7:0]  len,
  input  logic        is_halted,
  output logic        halt_n,
  output logic [15:0] AB_out,
  output logic        drive_AB,
  input  logic [7:0]  d_in,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  dma_state_e  state_q;
  logic [15:0] addr_q;
  logic [8:0]  cnt_q;
  logic [7:0]  tmo_q;
  logic [7:0]  data_q;
  logic        data_valid_q;
  logic        done_q;
  logic        err_q;

  // FSM and datapath.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= 16'h0000;
      cnt_q        <= 9'd0;
      tmo_q        <= 8'd0;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one clk wide.
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q  <= base_addr;
            cnt_q   <= len_to_count(len);
            tmo_q   <= HALT_TIMEOUT;
            state_q <= StHalt;
          end
        end

        StHalt: begin
          if (is_halted) begin
            state_q <= StFetch;
          end else if (pclk1) begin
            // Expire on the pulse that would take the counter to zero; a zero
            // timeout expires on the first pulse.
            if (tmo_q <= 8'd1) begin
              tmo_q   <= 8'd0;
              err_q   <= 1'b1;
              state_q <= StRelease;
            end else begin
              tmo_q <= tmo_q - 8'd1;
            end
          end
        end

        StFetch: begin
          // Losing the bus takes precedence over a coincident fetch slot.
          if (!is_halted) begin
            err_q   <= 1'b1;
            state_q <= StRelease;
          end else if (pclk0) begin
            data_q       <= d_in;
            data_valid_q <= 1'b1;
            addr_q       <= addr_q + 16'd1;
            cnt_q        <= cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
              state_q <= StRelease;
            end
          end
        end

        StRelease: begin
          // done follows err by at least one clk since err is raised on entry.
          if (!is_halted) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    halt_n     = 1'b1;
    drive_AB   = 1'b0;
    AB_out     = 16'h0000;
    busy       = (state_q != StIdle);
    data_out   = data_q;
    data_valid = data_valid_q;
    done       = done_q;
    err        = err_q;
    if (state_q == StHalt || state_q == StFetch) begin
      halt_n = 1'b0;
    end
    if (state_q == StFetch) begin
      drive_AB = 1'b1;
      AB_out   = addr_q;
    end
  end

endmodule

// File: tb/tb_maria_dma_master.sv
// Directed self-checking bench for maria_dma_master.
module tb_maria_dma_master;

  logic        clk_sys;
  logic        rst;
  logic        pclk0;
  logic        pclk1;
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  len;
  logic        is_halted;
  logic        halt_n;
  logic [15:0] AB_out;
  logic        drive_AB;
  logic [7:0]  d_in;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state shared by the tasks below.
  logic [15:0] exp_addr;
  logic [15:0] exp_daddr;
  logic [15:0] last_addr;
  int          nvalid;
  int          ndone;
  int          nerr;
  int          ndrive;
  int          phase = 0;

  maria_dma_master #(
    .HALT_TIMEOUT(8'd4)
  ) u_dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .pclk0     (pclk0),
    .pclk1     (pclk1),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .is_halted (is_halted),
    .halt_n    (halt_n),
    .AB_out    (AB_out),
    .drive_AB  (drive_AB),
    .d_in      (d_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Memory image: address-dependent byte that differs across both address halves.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  assign d_in = mem_byte(AB_out);

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clk. Captures are predicted from the pre-edge inputs; strobes are
  // sampled 1 time unit after the edge, when the new register values are stable.
  task automatic step();
    if (drive_AB && pclk0 && is_halted && !rst) begin
      check_eq("ab_out", {16'h0, AB_out}, {16'h0, exp_addr});
      last_addr = AB_out;
      exp_addr  = exp_addr + 16'd1;
    end
    @(posedge clk_sys);
    #1;
    phase = (phase + 1) % 4;
    pclk0 = (phase == 0);
    pclk1 = (phase == 2);
    if (data_valid) begin
      check_eq("data_out", {24'h0, data_out}, {24'h0, mem_byte(exp_daddr)});
      exp_daddr = exp_daddr + 16'd1;
      nvalid++;
    end
    if (done) ndone++;
    if (err) nerr++;
    if (done || err) check_eq("done_err_excl", {31'h0, done & err}, 32'h0);
    if (drive_AB) ndrive++;
  endtask

  task automatic clear_mon(input logic [15:0] base);
    exp_addr  = base;
    exp_daddr = base;
    last_addr = 16'h0;
    nvalid    = 0;
    ndone     = 0;
    nerr      = 0;
    ndrive    = 0;
  endtask

  task automatic pulse_start(input logic [15:0] base, input logic [7:0] l);
    start     = 1'b1;
    base_addr = base;
    len       = l;
    step();
    start     = 1'b0;
    base_addr = 16'hDEAD;
    len       = 8'h11;
  endtask

  // Full transfer: halt acknowledged after 'delay' pclk1 pulses (0 = already halted).
  task automatic run_xfer(input logic [15:0] base, input logic [7:0] l, input int delay,
                          input int exp_n, input logic [15:0] exp_last, input bit inject);
    int n1;
    int guard;
    bit injected;
    clear_mon(base);
    is_halted = (delay == 0);
    pulse_start(base, l);
    check_eq("busy_after_start", {31'h0, busy}, 32'h1);
    check_eq("halt_n_in_halt", {31'h0, halt_n}, 32'h0);
    if (delay == 0) begin
      check_eq("lat_halt_no_ab", {31'h0, drive_AB}, 32'h0);
      step();
      check_eq("lat_fetch_ab", {31'h0, drive_AB}, 32'h1);
    end else begin
      n1    = 0;
      guard = 0;
      while (n1 < delay && guard < 100) begin
        if (pclk1) n1++;
        step();
        guard++;
      end
      check_eq("halt_wait_no_ab", {31'h0, drive_AB}, 32'h0);
      is_halted = 1'b1;
    end
    guard    = 0;
    injected = 1'b0;
    while (halt_n == 1'b0 && guard < 1500) begin
      if (inject && !injected && drive_AB) begin
        start     = 1'b1;
        base_addr = 16'h2000;
        len       = 8'd9;
        injected  = 1'b1;
      end
      step();
      start = 1'b0;
      guard++;
    end
    check_eq("release_in_time", {31'h0, guard < 1500}, 32'h1);
    check_eq("final_valid_at_release", {31'h0, data_valid}, 32'h1);
    check_eq("valid_count", nvalid, exp_n);
    check_eq("last_ab", {16'h0, last_addr}, {16'h0, exp_last});
    check_eq("no_err", nerr, 0);
    check_eq("busy_in_release", {31'h0, busy}, 32'h1);
    is_halted = 1'b0;
    step();
    check_eq("done_pulse", {31'h0, done}, 32'h1);
    check_eq("done_no_err", {31'h0, err}, 32'h0);
    check_eq("idle_busy", {31'h0, busy}, 32'h0);
    step();
    check_eq("done_one_clk", {31'h0, done}, 32'h0);
    check_eq("done_count", ndone, 1);
    check_eq("stay_idle", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int n1;
    int guard;
    int d0;
    int e0;
    rst       = 1'b1;
    start     = 1'b1;   // coincident with reset, must be ignored
    base_addr = 16'h1234;
    len       = 8'd5;
    is_halted = 1'b1;
    pclk0     = 1'b0;
    pclk1     = 1'b0;
    clear_mon(16'h0);
    repeat (3) step();
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_halt_n", {31'h0, halt_n}, 32'h1);
    check_eq("rst_drive_ab", {31'h0, drive_AB}, 32'h0);
    check_eq("rst_ab_out", {16'h0, AB_out}, 32'h0);
    check_eq("rst_data_out", {24'h0, data_out}, 32'h0);
    check_eq("rst_strobes", {29'h0, data_valid, done, err}, 32'h0);
    rst   = 1'b0;
    start = 1'b0;
    is_halted = 1'b0;
    step();
    check_eq("post_rst_idle", {31'h0, busy}, 32'h0);

    // Halt acknowledged after 3 pclk1 pulses.
    run_xfer(16'h1F00, 8'd4, 3, 4, 16'h1F03, 1'b0);
    // Address wrap, already halted (2-clk latency).
    run_xfer(16'hFFFE, 8'd3, 0, 3, 16'h0000, 1'b0);
    // len = 0 is 256 bytes.
    run_xfer(16'h4000, 8'd0, 1, 256, 16'h40FF, 1'b0);
    // start while busy is ignored.
    run_xfer(16'h1000, 8'd4, 0, 4, 16'h1003, 1'b1);

    // Halt timeout: CPU never releases the bus.
    clear_mon(16'h7000);
    is_halted = 1'b0;
    pulse_start(16'h7000, 8'd5);
    n1    = 0;
    guard = 0;
    while (!err && guard < 60) begin
      if (pclk1) n1++;
      step();
      guard++;
    end
    check_eq("tmo_err", {31'h0, err}, 32'h1);
    check_eq("tmo_pclk1_count", n1, 4);
    check_eq("tmo_halt_n", {31'h0, halt_n}, 32'h1);
    check_eq("tmo_no_valid", nvalid, 0);
    check_eq("tmo_no_drive", ndrive, 0);
    step();
    check_eq("tmo_done", {31'h0, done}, 32'h1);
    check_eq("tmo_err_one_clk", {31'h0, err}, 32'h0);
    check_eq("tmo_idle", {31'h0, busy}, 32'h0);

    // CPU reclaims the bus after two bytes.
    clear_mon(16'h6000);
    is_halted = 1'b1;
    pulse_start(16'h6000, 8'd8);
    guard = 0;
    while (nvalid < 2 && guard < 100) begin
      step();
      guard++;
    end
    is_halted = 1'b0;
    step();
    check_eq("abandon_err", {31'h0, err}, 32'h1);
    check_eq("abandon_release", {30'h0, halt_n, drive_AB}, 32'h2);
    step();
    check_eq("abandon_done", {31'h0, done}, 32'h1);
    check_eq("abandon_err_one_clk", {31'h0, err}, 32'h0);
    check_eq("abandon_valid_count", nvalid, 2);

    // Reset mid-FETCH after the 2nd byte.
    clear_mon(16'h3000);
    is_halted = 1'b1;
    pulse_start(16'h3000, 8'd8);
    guard = 0;
    while (nvalid < 2 && guard < 100) begin
      step();
      guard++;
    end
    check_eq("pre_rst_fetching", {31'h0, drive_AB}, 32'h1);
    d0  = ndone;
    e0  = nerr;
    rst = 1'b1;
    step();
    check_eq("midrst_drive_ab", {31'h0, drive_AB}, 32'h0);
    check_eq("midrst_halt_n", {31'h0, halt_n}, 32'h1);
    check_eq("midrst_busy", {31'h0, busy}, 32'h0);
    check_eq("midrst_ab_out", {16'h0, AB_out}, 32'h0);
    check_eq("midrst_data_out", {24'h0, data_out}, 32'h0);
    rst = 1'b0;
    repeat (8) step();
    check_eq("midrst_no_done", ndone - d0, 0);
    check_eq("midrst_no_err", nerr - e0, 0);
    check_eq("midrst_still_idle", {31'h0, busy}, 32'h0);
    run_xfer(16'h5000, 8'd2, 2, 2, 16'h5001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
